// File: rtl/ddr_read_line_assembler_if.sv
// Bundle of the command, read-beat and line-output signals around the read line assembler.
// The slave view belongs to the assembler; the master view belongs to whatever drives it.
interface ddr_read_line_assembler_if #(
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 2,
  parameter int TAG_WIDTH  = 4,
  parameter int OUT_DEPTH  = 4
) ();

  logic                                 cmd_push_i;
  logic [TAG_WIDTH-1:0]                 cmd_tag_i;
  logic                                 cmd_ready_o;
  logic [DATA_WIDTH-1:0]                app_rd_data_i;
  logic                                 app_rd_data_valid_i;
  logic                                 app_rd_data_end_i;
  logic [BEATS*DATA_WIDTH-1:0]          line_data_o;
  logic [TAG_WIDTH-1:0]                 line_tag_o;
  logic                                 line_valid_o;
  logic                                 line_ready_i;
  logic [$clog2(OUT_DEPTH+1)-1:0]       outstanding_o;
  logic [2:0]                           err_o;
  logic                                 err_clear_i;

  modport master (
    output cmd_push_i, cmd_tag_i, app_rd_data_i, app_rd_data_valid_i,
           app_rd_data_end_i, line_ready_i, err_clear_i,
    input  cmd_ready_o, line_data_o, line_tag_o, line_valid_o,
           outstanding_o, err_o
  );

  modport slave (
    input  cmd_push_i, cmd_tag_i, app_rd_data_i, app_rd_data_valid_i,
           app_rd_data_end_i, line_ready_i, err_clear_i,
    output cmd_ready_o, line_data_o, line_tag_o, line_valid_o,
           outstanding_o, err_o
  );

endinterface

// File: rtl/ddr_read_line_assembler.sv
// Packs consecutive DDR read beats into cache lines, pairs each line with its command tag,
// and buffers finished lines behind a credit count so the backpressure-free read port never overruns.
module ddr_read_line_assembler #(
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 2,
  parameter int TAG_WIDTH  = 4,
  parameter int OUT_DEPTH  = 4
) (
  input logic                    ui_clk,
  input logic                    ui_rst,
  ddr_read_line_assembler_if.slave bus
);

  localparam int LINE_W = BEATS * DATA_WIDTH;
  localparam int PTR_W  = $clog2(OUT_DEPTH);
  localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
  localparam int BCNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(OUT_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W + 1)'(1);
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  logic [CNT_W-1:0]     r_outstanding;
  logic [PTR_W:0]       r_tagWr;
  logic [PTR_W:0]       r_tagRd;
  logic [PTR_W:0]       r_lineWr;
  logic [PTR_W:0]       r_lineRd;
  logic [TAG_WIDTH-1:0] r_tagMem     [OUT_DEPTH];
  logic [LINE_W-1:0]    r_lineMem    [OUT_DEPTH];
  logic [TAG_WIDTH-1:0] r_lineTagMem [OUT_DEPTH];
  logic [BCNT_W-1:0]    r_beatCnt;
  logic [LINE_W-1:0]    r_assembly;
  logic [2:0]           r_err;

  logic                 w_cmdReady;
  logic                 w_cmdAccept;
  logic                 w_tagEmpty;
  logic                 w_lineValid;
  logic                 w_linePop;
  logic                 w_beatAccept;
  logic                 w_lastBeat;
  logic                 w_lineDone;
  logic [2:0]           w_errEvent;
  logic [LINE_W-1:0]    w_lineNext;

  // Credit comes only from the registered count, so a pop frees a slot one cycle later.
  assign w_cmdReady   = (r_outstanding < DEPTH_C);
  assign w_cmdAccept  = bus.cmd_push_i & w_cmdReady;
  assign w_tagEmpty   = (r_tagWr == r_tagRd);
  assign w_lineValid  = (r_lineWr != r_lineRd);
  assign w_linePop    = w_lineValid & bus.line_ready_i;
  assign w_beatAccept = bus.app_rd_data_valid_i & ~w_tagEmpty;
  assign w_lastBeat   = (r_beatCnt == LAST_BEAT);
  assign w_lineDone   = w_beatAccept & w_lastBeat;

  assign w_errEvent = {bus.cmd_push_i & ~w_cmdReady,
                       bus.app_rd_data_valid_i & w_tagEmpty,
                       w_beatAccept & (bus.app_rd_data_end_i != w_lastBeat)};

  always_comb begin
    w_lineNext = r_assembly;
    w_lineNext[(BEATS-1)*DATA_WIDTH +: DATA_WIDTH] = bus.app_rd_data_i;
  end

  always_ff @(posedge ui_clk or negedge ui_rst) begin
    if (!ui_rst) begin
      r_outstanding <= '0;
      r_tagWr       <= '0;
      r_tagRd       <= '0;
      r_lineWr      <= '0;
      r_lineRd      <= '0;
      r_beatCnt     <= '0;
      r_assembly    <= '0;
      r_err         <= '0;
    end else begin
      unique case ({w_cmdAccept, w_linePop})
        2'b10:   r_outstanding <= r_outstanding + CNT_ONE;
        2'b01:   r_outstanding <= r_outstanding - CNT_ONE;
        default: r_outstanding <= r_outstanding;
      endcase

      if (w_cmdAccept) r_tagWr <= r_tagWr + PTR_ONE;
      if (w_linePop)   r_lineRd <= r_lineRd + PTR_ONE;

      if (w_beatAccept) begin
        for (int k = 0; k < BEATS; k++) begin
          if (r_beatCnt == BCNT_W'(k)) r_assembly[k*DATA_WIDTH +: DATA_WIDTH] <= bus.app_rd_data_i;
        end
        r_beatCnt <= w_lastBeat ? '0 : r_beatCnt + BCNT_ONE;
      end

      if (w_lineDone) begin
        r_tagRd  <= r_tagRd + PTR_ONE;
        r_lineWr <= r_lineWr + PTR_ONE;
      end

      // A fresh error event outranks a clear arriving in the same cycle.
      r_err <= (bus.err_clear_i ? 3'b000 : r_err) | w_errEvent;
    end
  end

  // Storage needs no reset: the pointers decide what is live.
  always_ff @(posedge ui_clk) begin
    if (w_cmdAccept) r_tagMem[r_tagWr[PTR_W-1:0]] <= bus.cmd_tag_i;
    if (w_lineDone) begin
      r_lineMem[r_lineWr[PTR_W-1:0]]    <= w_lineNext;
      r_lineTagMem[r_lineWr[PTR_W-1:0]] <= r_tagMem[r_tagRd[PTR_W-1:0]];
    end
  end

  assign bus.cmd_ready_o   = w_cmdReady;
  assign bus.line_valid_o  = w_lineValid;
  assign bus.line_data_o   = w_lineValid ? r_lineMem[r_lineRd[PTR_W-1:0]] : '0;
  assign bus.line_tag_o    = w_lineValid ? r_lineTagMem[r_lineRd[PTR_W-1:0]] : '0;
  assign bus.outstanding_o = r_outstanding;
  assign bus.err_o         = r_err;

endmodule
